game_flow_ctrl: RTL

GAME_FLOW_CTRL -- requirements
Module: game_flow_ctrl

---
 rtl/game_flow_ctrl_pkg.sv | 26 ++
 rtl/game_flow_timer.sv | 34 +++
 rtl/game_flow_ctrl.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/game_flow_ctrl_pkg.sv
// Shared game constants: state encodings and parameter defaults for game_flow_ctrl.
// PAUSED exists only when GAME_FLOW_PAUSE_EN is defined.
package game_flow_ctrl_pkg;

  localparam int unsigned NUM_LANES_DEF      = 4;
  localparam int unsigned LIVES_INI_DEF      = 3;
  localparam int unsigned LEVEL_MAX_DEF      = 15;
  localparam int unsigned RESPAWN_CYCLES_DEF = 25_000_000;
  localparam int unsigned SCORE_MAX          = 99;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RUNNING   = 3'd1,
    ST_DYING     = 3'd2,
    ST_GAME_OVER = 3'd3
`ifdef GAME_FLOW_PAUSE_EN
    ,
    ST_PAUSED    = 3'd4
`endif
  } state_e;

  function automatic logic [6:0] score_inc(input logic [6:0] score);
    return (score < 7'(SCORE_MAX)) ? score + 7'd1 : score;
  endfunction

endpackage

// File: rtl/game_flow_timer.sv
// Respawn dwell timer: load a start value, count down on request, flag zero.
module game_flow_timer #(
  parameter int unsigned WIDTH = 25
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             dec_i,
  output logic             done_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/game_flow_ctrl.sv
// Game flow controller: start/lives/level/score sequencing for the frog game.
// Optional PAUSED state enabled by defining GAME_FLOW_PAUSE_EN.
module game_flow_ctrl
  import game_flow_ctrl_pkg::*;
#(
  parameter int unsigned NUM_LANES      = NUM_LANES_DEF,
  parameter int unsigned LIVES_INI      = LIVES_INI_DEF,
  parameter int unsigned LEVEL_MAX      = LEVEL_MAX_DEF,
  parameter int unsigned RESPAWN_CYCLES = RESPAWN_CYCLES_DEF
) (
  input  logic                 i_Clk,
  input  logic                 i_Rst_L,
  input  logic                 i_Start,
  input  logic [NUM_LANES-1:0] i_Hit,
  input  logic                 i_Goal,
  output logic [2:0]           o_State,
  output logic                 o_Game_Active,
  output logic                 o_Respawn,
  output logic [2:0]           o_Lives,
  output logic [3:0]           o_Level,
  output logic                 o_Level_Up,
  output logic [6:0]           o_Score
);

  localparam int unsigned TMR_W = (RESPAWN_CYCLES > 1) ? $clog2(RESPAWN_CYCLES) : 1;

  state_e     state_q, state_d;
  logic [2:0] lives_q, lives_d;
  logic [3:0] level_q, level_d;
  logic [6:0] score_q, score_d;
  logic       respawn_q, respawn_d;
  logic       level_up_q, level_up_d;
  logic       active_q, active_d;
  logic       start_prev_q;
  logic       start_edge;
  logic       any_hit;
  logic       tmr_load, tmr_dec, tmr_done;

  assign start_edge = i_Start & ~start_prev_q;
  assign any_hit    = |i_Hit;

  game_flow_timer #(
    .WIDTH (TMR_W)
  ) u_timer (
    .clk_i      (i_Clk),
    .rst_ni     (i_Rst_L),
    .load_i     (tmr_load),
    .load_val_i (TMR_W'(RESPAWN_CYCLES - 1)),
    .dec_i      (tmr_dec),
    .done_o     (tmr_done)
  );

  always_comb begin
    state_d    = state_q;
    lives_d    = lives_q;
    level_d    = level_q;
    score_d    = score_q;
    respawn_d  = 1'b0;
    level_up_d = 1'b0;
    tmr_load   = 1'b0;
    tmr_dec    = 1'b0;

    case (state_q)
      ST_IDLE, ST_GAME_OVER: begin
        if (state_q == ST_GAME_OVER) lives_d = '0;
        if (start_edge) begin
          state_d   = ST_RUNNING;
          lives_d   = 3'(LIVES_INI);
          level_d   = '0;
          score_d   = '0;
          respawn_d = 1'b1;
        end
      end
      ST_RUNNING: begin
        // Hit outranks goal; the goal of the same cycle is dropped.
        if (any_hit) begin
          if (lives_q <= 3'd1) begin
            state_d = ST_GAME_OVER;
            lives_d = '0;
          end else begin
            state_d  = ST_DYING;
            lives_d  = lives_q - 3'd1;
            tmr_load = 1'b1;
          end
        end else if (i_Goal) begin
          score_d   = score_inc(score_q);
          respawn_d = 1'b1;
          if (level_q < 4'(LEVEL_MAX)) begin
            level_d    = level_q + 4'd1;
            level_up_d = 1'b1;
          end
        end
`ifdef GAME_FLOW_PAUSE_EN
        else if (start_edge) begin
          state_d = ST_PAUSED;
        end
`endif
      end
      ST_DYING: begin
        if (tmr_done) begin
          state_d   = ST_RUNNING;
          respawn_d = 1'b1;
        end else begin
          tmr_dec = 1'b1;
        end
      end
`ifdef GAME_FLOW_PAUSE_EN
      ST_PAUSED: begin
        if (start_edge) state_d = ST_RUNNING;
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    active_d = (state_d == ST_RUNNING);
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q      <= ST_IDLE;
      lives_q      <= '0;
      level_q      <= '0;
      score_q      <= '0;
      respawn_q    <= 1'b0;
      level_up_q   <= 1'b0;
      active_q     <= 1'b0;
      start_prev_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      lives_q      <= lives_d;
      level_q      <= level_d;
      score_q      <= score_d;
      respawn_q    <= respawn_d;
      level_up_q   <= level_up_d;
      active_q     <= active_d;
      start_prev_q <= i_Start;
    end
  end

  assign o_State       = state_q;
  assign o_Game_Active = active_q;
  assign o_Respawn     = respawn_q;
  assign o_Lives       = lives_q;
  assign o_Level       = level_q;
  assign o_Level_Up    = level_up_q;
  assign o_Score       = score_q;

endmodule
